// File: rtl/alu_exec_ctrl.sv
// ALU control decode + execute; ADD/SUB/SLL/AND in 1 cycle, optional iterative MUL in WIDTH cycles.
// Latency 1 (MUL: WIDTH); in_ready = idle && (!out_valid || out_ready). MUL enabled by `define ALU_MUL_EN.
module alu_exec_ctrl #(
    parameter int WIDTH  = 16,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic [2:0]        alu_ctl
);
    localparam int SH_W = $clog2(WIDTH);
    // func is compared against 4-bit codes, so widen narrow fields first
    localparam int FW   = (FUNC_W > 4) ? FUNC_W : 4;

    localparam logic [2:0] CTL_AND = 3'b000;
    localparam logic [2:0] CTL_ADD = 3'b010;
    localparam logic [2:0] CTL_SLL = 3'b011;
    localparam logic [2:0] CTL_MUL = 3'b100;
    localparam logic [2:0] CTL_SUB = 3'b110;

    logic [FW-1:0]    func_x;
    logic [2:0]       dec_ctl;
    logic [WIDTH-1:0] exec_res;
    logic             accept;

    assign func_x = FW'(func);
    assign accept = in_valid && in_ready;

    always_comb begin
        dec_ctl = CTL_AND;
        case (alu_op)
            2'b00: dec_ctl = CTL_ADD;
            2'b01: dec_ctl = CTL_SUB;
            2'b10: begin
                if (func_x == FW'(0))      dec_ctl = CTL_ADD;
                else if (func_x == FW'(1)) dec_ctl = CTL_SUB;
                else if (func_x == FW'(2)) dec_ctl = CTL_SLL;
                else if (func_x == FW'(3)) dec_ctl = CTL_AND;
`ifdef ALU_MUL_EN
                else if (func_x == FW'(4)) dec_ctl = CTL_MUL;
`endif
                else                       dec_ctl = CTL_AND;
            end
            default: dec_ctl = CTL_AND;
        endcase
    end

    always_comb begin
        exec_res = a & b;
        case (dec_ctl)
            CTL_ADD: exec_res = a + b;
            CTL_SUB: exec_res = a - b;
            CTL_SLL: exec_res = a << b[SH_W-1:0];
            default: exec_res = a & b;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SH_W-1:0]  cnt;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            alu_ctl   <= CTL_AND;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_ctl == CTL_MUL) begin
                            mcand     <= a;
                            mplier    <= b;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= MUL;
                        end else begin
                            result    <= exec_res;
                            zero      <= (exec_res == '0);
                            alu_ctl   <= dec_ctl;
                            out_valid <= 1'b1;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    // shift-and-add, always WIDTH steps regardless of operand values
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SH_W'(1);
                    if (cnt == SH_W'(WIDTH - 1)) begin
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        alu_ctl   <= CTL_MUL;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            alu_ctl   <= CTL_AND;
        end else if (accept) begin
            result    <= exec_res;
            zero      <= (exec_res == '0);
            alu_ctl   <= dec_ctl;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl at default parameters; follows ALU_MUL_EN if defined.
module tb_alu_exec_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [3:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic [2:0]  alu_ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.WIDTH(16), .FUNC_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func      (func),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .alu_ctl   (alu_ctl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present a request one cycle; caller guarantees in_ready at the edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] fn,
                         input logic [15:0] aa, input logic [15:0] bb);
        alu_op   = op;
        func     = fn;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, returning cycles taken and cycles in_ready was low.
    task automatic wait_result(output int n, output int rdy_low);
        n       = 0;
        rdy_low = (in_ready == 1'b0) ? 1 : 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!out_valid && !in_ready) rdy_low++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, low, stale;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; func = 4'h0; a = '0; b = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_ctl", alu_ctl, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD, R-type and lw/sw forms
        issue(2'b10, 4'h0, 16'h1234, 16'h0001);
        check("add_vld", out_valid, 1);
        check("add_res", result, 16'h1235);
        check("add_ctl", alu_ctl, 3'b010);
        check("add_zero", zero, 0);
        issue(2'b00, 4'h7, 16'h1234, 16'h0001);
        check("addi_res", result, 16'h1235);
        check("addi_ctl", alu_ctl, 3'b010);

        // branch compare and wrap
        issue(2'b01, 4'h0, 16'h00AA, 16'h00AA);
        check("beq_res", result, 0);
        check("beq_zero", zero, 1);
        check("beq_ctl", alu_ctl, 3'b110);
        issue(2'b10, 4'h0, 16'hFFFF, 16'h0001);
        check("wrap_res", result, 0);
        check("wrap_zero", zero, 1);

        // SLL uses only b[3:0]; jmp decodes as AND
        issue(2'b10, 4'h2, 16'h0001, 16'h0013);
        check("sll_res", result, 16'h0008);
        check("sll_ctl", alu_ctl, 3'b011);
        issue(2'b11, 4'h0, 16'h1234, 16'h00FF);
        check("jmp_ctl", alu_ctl, 3'b000);
        check("jmp_res", result, 16'h0034);

        // func 0100
        issue(2'b10, 4'h4, 16'h00FF, 16'h0101);
`ifdef ALU_MUL_EN
        check("mul_busy_rdy", in_ready, 0);
        check("mul_busy_vld", out_valid, 0);
        wait_result(n, low);
        check("mul_latency", n, 16);
        check("mul_rdy_low", low, 16);
        check("mul_res", result, 16'hFFFF);
        check("mul_ctl", alu_ctl, 3'b100);
        check("mul_zero", zero, 0);
        @(posedge clk); #1;
        issue(2'b10, 4'h4, 16'h1234, 16'h0000);
        wait_result(n, low);
        check("mul0_latency", n, 16);
        check("mul0_res", result, 0);
        check("mul0_zero", zero, 1);
`else
        check("and4_vld", out_valid, 1);
        check("and4_res", result, 16'h0001);
        check("and4_ctl", alu_ctl, 3'b000);
`endif

        // backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(2'b10, 4'h0, 16'h0005, 16'h0006);
        check("bp_res", result, 16'h000B);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rdy_low", in_ready, 0);
            check("bp_res_hold", result, 16'h000B);
        end
        alu_op = 2'b01; func = 4'h0; a = 16'h000A; b = 16'h0003; in_valid = 1'b1;
        #1;
        check("bp_rdy_none", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_comb", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_vld", out_valid, 1);
        check("b2b_res", result, 16'h0007);
        check("b2b_ctl", alu_ctl, 3'b110);
        @(posedge clk); #1;
        check("drain_vld", out_valid, 0);

        // reset in the middle of a MUL (AND result when MUL absent)
        issue(2'b10, 4'h4, 16'h00FF, 16'h0101);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("mrst_vld", out_valid, 0);
        check("mrst_res", result, 0);
        check("mrst_rdy", in_ready, 1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'b10, 4'h0, 16'h0002, 16'h0003);
        check("post_vld", out_valid, 1);
        check("post_res", result, 16'h0005);
        check("post_ctl", alu_ctl, 3'b010);
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("no_stale", stale, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
